dm_arbiter: RTL and testbench

Two-master arbiter that shares the single-ported word-addressed data memory between the CPU data port (master 0) and the test/loader port (master 1). It sits between the requesters and the data memory. It drives the memory's write-enable, address and write-data, and it returns registered read data with a response strobe. Arbitration is round-robin with an optional lock for back-to-back bursts, and it also keeps per-master access counters.

---
 rtl/dm_arb_pkg.sv | 21 ++
 rtl/dm_arb_rr.sv | 26 ++
 rtl/dm_arbiter.sv | 105 ++++++++++
 tb/tb_dm_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Optional write log enabled by DM_WRITE_LOG_EN.
package dm_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef logic mid_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } own_e;

  localparam string LOG_FMT = "@%h: *%h <= %h";

  function automatic own_e own_of(input mid_t m);
    return m ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// Round-robin pick over two requesters with lock owner.
// Pure combinational; returns a one-hot grant.
module dm_arb_rr
  import dm_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  mid_t                   last,
  input  own_e                   own,
  output logic [NUM_MASTERS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (own)
      OWN_M0: gnt[0] = req[0];
      OWN_M1: gnt[1] = req[1];
      default: begin
        unique case (1'b1)
          (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
          default:        gnt = req;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master data-memory arbiter with lock and counters.
// Define DM_WRITE_LOG_EN to print committed writes.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_we,
  input  logic [1:0]        m_lock,
  input  logic [ADDR_W-1:0] m_addr0,
  input  logic [ADDR_W-1:0] m_addr1,
  input  logic [DATA_W-1:0] m_wdata0,
  input  logic [DATA_W-1:0] m_wdata1,
  input  logic [ADDR_W-1:0] m_pc0,
  input  logic [ADDR_W-1:0] m_pc1,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_rvalid,
  output logic [1:0]        m_err,
  output logic [DATA_W-1:0] m_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       cnt0,
  output logic [31:0]       cnt1
);

  own_e              own;
  mid_t              last;
  logic [1:0]        gnt_rr;
  mid_t              sel;
  logic              any;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              we_s;
  logic              lock_s;
  logic              mis;
  logic              own_idle;

  dm_arb_rr u_rr (
    .req  (m_req),
    .last (last),
    .own  (own),
    .gnt  (gnt_rr)
  );

  // Reset kills the grant at once so no write reaches the edge
  assign m_gnt   = reset ? gnt_rr : 2'b00;
  assign any     = |m_gnt;
  assign sel     = m_gnt[1];
  assign addr_s  = sel ? m_addr1 : m_addr0;
  assign wdata_s = sel ? m_wdata1 : m_wdata0;
  assign we_s    = m_we[sel];
  assign lock_s  = m_lock[sel];
  assign mis     = addr_s[1:0] != 2'b00;

  assign mem_we    = any && we_s && !mis;
  assign mem_addr  = any ? addr_s : '0;
  assign mem_wdata = any ? wdata_s : '0;

  assign own_idle = ((own == OWN_M0) && !m_req[0])
                 || ((own == OWN_M1) && !m_req[1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rvalid <= 2'b00;
      m_err    <= 2'b00;
      m_rdata  <= '0;
      cnt0     <= '0;
      cnt1     <= '0;
      last     <= 1'b1;
      own      <= OWN_NONE;
    end else begin
      m_rvalid <= m_gnt;
      m_err    <= mis ? m_gnt : 2'b00;
      m_rdata  <= (any && !we_s && !mis) ? mem_rdata : '0;
      if (m_gnt[0]) cnt0 <= cnt0 + 32'd1;
      if (m_gnt[1]) cnt1 <= cnt1 + 32'd1;
      if (any) begin
        last <= sel;
        own  <= lock_s ? own_of(sel) : OWN_NONE;
      end else if (own_idle) begin
        own  <= OWN_NONE;
      end
    end
  end

`ifdef DM_WRITE_LOG_EN
  logic [ADDR_W-1:0] pc_s;
  assign pc_s = sel ? m_pc1 : m_pc0;

  always @(posedge clk) begin
    if (reset && mem_we)
      $display("%s", $sformatf(LOG_FMT, pc_s, mem_addr, mem_wdata));
  end
`else
  logic unused_pc;
  assign unused_pc = ^{m_pc0, m_pc1};
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter.
// Responses are queued at grant time and checked on rvalid.
module tb_dm_arbiter;

  typedef struct {
    int          cyc;
    logic [1:0]  v;
    logic [1:0]  e;
    logic [31:0] d;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  m_req = '0, m_we = '0, m_lock = '0;
  logic [31:0] m_addr0 = '0, m_addr1 = '0;
  logic [31:0] m_wdata0 = '0, m_wdata1 = '0;
  logic [31:0] m_pc0 = 32'h100, m_pc1 = 32'h3000;
  logic [1:0]  m_gnt, m_rvalid, m_err;
  logic [31:0] m_rdata, mem_addr, mem_wdata, mem_rdata, cnt0, cnt1;
  logic        mem_we;

  logic [31:0] mem [0:4095];
  resp_t       q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] exp_cnt0 = '0, exp_cnt1 = '0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
    .m_addr0(m_addr0), .m_addr1(m_addr1),
    .m_wdata0(m_wdata0), .m_wdata1(m_wdata1),
    .m_pc0(m_pc0), .m_pc1(m_pc1),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err),
    .m_rdata(m_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  assign mem_rdata = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;
    cyc <= cyc + 1;
  end

  // Scoreboard: each grant matures one cycle later
  always @(negedge clk) begin
    resp_t r;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      r = q.pop_front();
      checks++;
      if (m_rvalid !== r.v || m_err !== r.e || m_rdata !== r.d) begin
        failures++;
        $display("FAIL resp@%0d: got v=%b e=%b d=%h want v=%b e=%b d=%h",
                 r.cyc, m_rvalid, m_err, m_rdata, r.v, r.e, r.d);
      end
    end else if (m_rvalid !== 2'b00) begin
      checks++;
      failures++;
      $display("FAIL spurious_rvalid: got %b want 00", m_rvalid);
    end
  end

  task automatic push(input logic [1:0] v, input logic [1:0] e,
                      input logic [31:0] d);
    resp_t r;
    r.cyc = cyc;
    r.v = v;
    r.e = e;
    r.d = d;
    q.push_back(r);
    if (v[0]) exp_cnt0++;
    if (v[1]) exp_cnt1++;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [1:0] lock,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] w0, input logic [31:0] w1);
    m_req = req;
    m_we = we;
    m_lock = lock;
    m_addr0 = a0;
    m_addr1 = a1;
    m_wdata0 = w0;
    m_wdata1 = w1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(2'b11, 2'b11, 2'b00, 32'h8, 32'hc, 32'h1, 32'h2);
    repeat (2) @(negedge clk);
    checks++;
    if (m_gnt !== 2'b00 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_gnt: got gnt=%b we=%b want 00 0", m_gnt, mem_we);
    end
    checks++;
    if (mem_addr !== 0 || mem_wdata !== 0) begin
      failures++;
      $display("FAIL reset_mem: got a=%h d=%h want 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if (m_rvalid !== 0 || m_err !== 0 || m_rdata !== 0) begin
      failures++;
      $display("FAIL reset_resp: got v=%b e=%b d=%h want 0", m_rvalid, m_err, m_rdata);
    end
    checks++;
    if (cnt0 !== 0 || cnt1 !== 0) begin
      failures++;
      $display("FAIL reset_cnt: got %h %h want 0 0", cnt0, cnt1);
    end
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic test_alternate();
    logic [1:0] g;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0);
      @(negedge clk);
      g = (i % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if (m_gnt !== g) begin
        failures++;
        $display("FAIL alt_gnt%0d: got %b want %b", i, m_gnt, g);
      end
      push(g, 2'b00, (i % 2 == 1) ? 32'hA000_0001 : 32'hA000_0000);
    end
    idle();
    checks++;
    if (cnt0 !== exp_cnt0 || cnt1 !== exp_cnt1) begin
      failures++;
      $display("FAIL alt_cnt: got %h %h want %h %h", cnt0, cnt1, exp_cnt0, exp_cnt1);
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    drive(2'b10, 2'b10, 2'b00, 0, 32'h10, 0, 32'h1234_5678);
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b10 || mem_we !== 1'b1 || mem_addr !== 32'h10
        || mem_wdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL wr_drive: got g=%b we=%b a=%h d=%h want 10 1 10 12345678",
               m_gnt, mem_we, mem_addr, mem_wdata);
    end
    push(2'b10, 2'b00, 32'h0);
    @(posedge clk); #1;
    drive(2'b01, 2'b00, 2'b00, 32'h10, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b01 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rd_drive: got g=%b we=%b want 01 0", m_gnt, mem_we);
    end
    push(2'b01, 2'b00, 32'h1234_5678);
    idle();
  endtask

  task automatic test_lock();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive(2'b11, 2'b10, (k < 3) ? 2'b10 : 2'b00, 32'h0,
            32'h40 + 32'(4 * k), 0, 32'hB000_0000 + 32'(k));
      @(negedge clk);
      checks++;
      if (m_gnt !== 2'b10) begin
        failures++;
        $display("FAIL burst%0d: got %b want 10", k, m_gnt);
      end
      push(2'b10, 2'b00, 32'h0);
    end
    @(posedge clk); #1;
    drive(2'b01, 2'b00, 2'b00, 32'h0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b01) begin
      failures++;
      $display("FAIL after_burst: got %b want 01", m_gnt);
    end
    push(2'b01, 2'b00, 32'hA000_0000);
    @(posedge clk); #1;
    drive(2'b10, 2'b10, 2'b10, 0, 32'h50, 0, 32'hC0DE);
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b10) begin
      failures++;
      $display("FAIL lock_set: got %b want 10", m_gnt);
    end
    push(2'b10, 2'b00, 32'h0);
    @(posedge clk); #1;
    drive(2'b01, 2'b00, 2'b10, 32'h0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b00) begin
      failures++;
      $display("FAIL lock_hold: got %b want 00", m_gnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b01) begin
      failures++;
      $display("FAIL lock_drop: got %b want 01", m_gnt);
    end
    push(2'b01, 2'b00, 32'hA000_0000);
    idle();
    checks++;
    if (mem[19] !== 32'hB000_0003 || mem[20] !== 32'hC0DE) begin
      failures++;
      $display("FAIL burst_mem: got %h %h want b0000003 0000c0de", mem[19], mem[20]);
    end
  endtask

  task automatic test_misaligned();
    @(posedge clk); #1;
    drive(2'b01, 2'b01, 2'b00, 32'h6, 0, 32'hFFFF, 0);
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b01 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL mis_drive: got g=%b we=%b want 01 0", m_gnt, mem_we);
    end
    push(2'b01, 2'b01, 32'h0);
    idle();
    checks++;
    if (cnt0 !== exp_cnt0) begin
      failures++;
      $display("FAIL mis_cnt: got %h want %h", cnt0, exp_cnt0);
    end
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    force dut.cnt0 = 32'hFFFF_FFFF;
    #1;
    release dut.cnt0;
    exp_cnt0 = 32'hFFFF_FFFF;
    drive(2'b01, 2'b00, 2'b00, 32'h8, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b01) begin
      failures++;
      $display("FAIL wrap_gnt: got %b want 01", m_gnt);
    end
    push(2'b01, 2'b00, 32'hA000_0002);
    idle();
    checks++;
    if (cnt0 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_cnt: got %h want 00000000", cnt0);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    drive(2'b01, 2'b01, 2'b00, 32'h20, 0, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b01 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst: got g=%b we=%b want 01 1", m_gnt, mem_we);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (m_gnt !== 0 || mem_we !== 0 || m_rvalid !== 0 || m_err !== 0
        || m_rdata !== 0 || cnt0 !== 0 || cnt1 !== 0) begin
      failures++;
      $display("FAIL mid_rst: got g=%b we=%b v=%b c=%h/%h want all 0",
               m_gnt, mem_we, m_rvalid, cnt0, cnt1);
    end
    exp_cnt0 = '0;
    exp_cnt1 = '0;
    @(posedge clk); #1;
    checks++;
    if (mem[8] !== 32'hA000_0008) begin
      failures++;
      $display("FAIL rst_drop_wr: got %h want a0000008", mem[8]);
    end
    drive(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b01) begin
      failures++;
      $display("FAIL rst_tie: got %b want 01", m_gnt);
    end
    push(2'b01, 2'b00, 32'hA000_0000);
    idle();
    checks++;
    if (cnt0 !== exp_cnt0 || cnt1 !== exp_cnt1) begin
      failures++;
      $display("FAIL rst_cnt: got %h %h want %h %h", cnt0, cnt1, exp_cnt0, exp_cnt1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_alternate();
    test_write_read();
    test_lock();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    idle();
    idle();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
